tpn_collector: RTL and testbench

TPN_COLLECTOR -- requirements
Module: tpn_collector

---
 rtl/bloom_pkg.sv | 24 ++
 rtl/tpn_fifo.sv | 66 ++++++
 rtl/tpn_collector.sv | 126 ++++++++++++
 tb/tb_tpn_collector.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bloom_pkg.sv
// Shared parameters, FSM state type and the lowest-set-bit encoder for the
// true-page-number collector.
package bloom_pkg;
  localparam int PPB       = 64;
  localparam int NOP_WIDTH = 12;
  localparam int MAX_TPN   = 8;
  localparam int IDX_W     = $clog2(PPB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [PPB-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = PPB - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/tpn_fifo.sv
// Result FIFO: DEPTH entries of WIDTH bits, registered head, synchronous clear.
// A pop frees a slot on the same edge, so push and pop both succeed when full.
module tpn_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/tpn_collector.sv
// Turns per-block page-match bitmaps into a stream of global true-page numbers,
// keeping at most MAX_TPN per scan and flagging any match dropped beyond that.
module tpn_collector #(
  parameter int PPB       = bloom_pkg::PPB,
  parameter int NOP_WIDTH = bloom_pkg::NOP_WIDTH,
  parameter int MAX_TPN   = bloom_pkg::MAX_TPN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            in_bidx,
  input  logic [PPB-1:0]        in_eq,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NOP_WIDTH-1:0]  out_tpn,
  output logic [3:0]            num_tpn,
  output logic                  overflow,
  output logic                  done,
  output bloom_pkg::state_e     dbg_state
);
  import bloom_pkg::*;

  // Handshakes: a beat moves on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and payload is only meaningful while valid=1.

  state_e               state_q, state_d;
  logic [PPB-1:0]       bitmap_q, bitmap_d;
  logic [5:0]           bidx_q, bidx_d;
  logic                 last_q, last_d;
  logic [3:0]           num_q, num_d;
  logic                 ovf_q, ovf_d;
  logic [IDX_W-1:0]     j;
  logic [NOP_WIDTH-1:0] tpn;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign j         = lowest_set(bitmap_q);
  assign tpn       = NOP_WIDTH'(bidx_q) * NOP_WIDTH'(PPB) + NOP_WIDTH'(j);
  assign fifo_pop  = out_ready && !fifo_empty;
  assign out_valid = !fifo_empty;
  assign in_ready  = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign num_tpn   = num_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    bitmap_d  = bitmap_q;
    bidx_d    = bidx_q;
    last_d    = last_q;
    num_d     = num_q;
    ovf_d     = ovf_q;
    fifo_push = 1'b0;
    if (scan_clr) begin
      state_d  = IDLE;
      bitmap_d = '0;
      last_d   = 1'b0;
      num_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            bitmap_d = in_eq;
            bidx_d   = in_bidx;
            last_d   = in_last;
            state_d  = SCAN;
          end
        end
        SCAN: begin
          if (bitmap_q == '0) begin
            state_d = last_q ? DONE : IDLE;
          end else if (num_q < 4'(MAX_TPN)) begin
            // A full FIFO stalls extraction unless it pops on this same edge.
            if (!fifo_full || fifo_pop) begin
              fifo_push = 1'b1;
              bitmap_d  = bitmap_q & ~(PPB'(1) << j);
              num_d     = num_q + 4'd1;
            end
          end else begin
            bitmap_d = bitmap_q & ~(PPB'(1) << j);
            ovf_d    = 1'b1;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      bitmap_q <= '0;
      bidx_q   <= '0;
      last_q   <= 1'b0;
      num_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitmap_q <= bitmap_d;
      bidx_q   <= bidx_d;
      last_q   <= last_d;
      num_q    <= num_d;
      ovf_q    <= ovf_d;
    end
  end

  tpn_fifo #(
    .DEPTH (MAX_TPN),
    .WIDTH (NOP_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (scan_clr),
    .push  (fifo_push),
    .wdata (tpn),
    .pop   (fifo_pop),
    .rdata (out_tpn),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_tpn_collector.sv
// Bench for tpn_collector: directed scenarios plus randomized scans, scored
// against a per-scan model of which matches are kept and in what order.
module tb_tpn_collector;
  import bloom_pkg::*;

  logic        clk = 1'b0;
  logic        rst, scan_clr, in_valid, in_last, out_ready;
  logic        in_ready, out_valid, overflow, done;
  logic [5:0]  in_bidx;
  logic [63:0] in_eq;
  logic [11:0] out_tpn;
  logic [3:0]  num_tpn;
  state_e      dbg_state;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [11:0] exp_q[$];
  int          m_num;
  bit          m_ovf, m_done;
  int          ready_mode;

  tpn_collector dut (
    .clk       (clk),
    .rst       (rst),
    .scan_clr  (scan_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bidx   (in_bidx),
    .in_eq     (in_eq),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tpn   (out_tpn),
    .num_tpn   (num_tpn),
    .overflow  (overflow),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  // out_ready driver: 0 = hold low, 1 = always high, 2 = random
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 2) out_ready = ($urandom_range(0, 1) == 1);
      else                 out_ready = (ready_mode == 1);
    end
  end

  // scoreboard: every accepted output must be the next expected page
  initial begin
    forever begin
      @(negedge clk);
      if (rst && !scan_clr && out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("out_extra", out_valid, 0);
        else                   check_eq("out_tpn", out_tpn, exp_q.pop_front());
      end
    end
  end

  task automatic model_clear();
    exp_q.delete();
    m_num  = 0;
    m_ovf  = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic wait_in_ready();
    int cyc;
    @(negedge clk);
    cyc = 0;
    while (!in_ready && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) check_eq("in_ready_timeout", in_ready, 1);
  endtask

  task automatic send_block(input logic [5:0] bidx, input logic [63:0] eq, input logic last);
    int cyc;
    int nbits;
    int t;
    wait_in_ready();
    in_valid = 1'b1;
    in_bidx  = bidx;
    in_eq    = eq;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    nbits = 0;
    for (int k = 0; k < 64; k++) begin
      if (eq[k]) begin
        nbits++;
        if (m_num < MAX_TPN) begin
          t = int'(bidx) * PPB + k;
          exp_q.push_back(t[11:0]);
          m_num++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    if (last) m_done = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!(in_ready || done) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("scan_cycles", cyc, nbits + 1);
  endtask

  task automatic clear_scan();
    @(posedge clk);
    #1 scan_clr = 1'b1;
    @(posedge clk);
    #1 scan_clr = 1'b0;
    model_clear();
    @(negedge clk);
    check_eq("clr_out_valid", out_valid, 0);
    check_eq("clr_num_tpn", num_tpn, 0);
    check_eq("clr_in_ready", in_ready, 1);
    check_eq("clr_done", done, 0);
  endtask

  task automatic end_scan();
    int cyc;
    ready_mode = 1;
    @(negedge clk);
    cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("drain_left", exp_q.size(), 0);
    check_eq("drain_out_valid", out_valid, 0);
    check_eq("num_tpn", num_tpn, m_num);
    check_eq("overflow", overflow, m_ovf);
    check_eq("done", done, m_done);
    clear_scan();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 1);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_tpn"}, out_tpn, 0);
    check_eq({tag, "_num_tpn"}, num_tpn, 0);
    check_eq({tag, "_overflow"}, overflow, 0);
    check_eq({tag, "_done"}, done, 0);
  endtask

  initial begin
    logic [63:0] eq;
    int nblk;
    rst = 1'b0; scan_clr = 1'b0; in_valid = 1'b0;
    in_bidx = '0; in_eq = '0; in_last = 1'b0;
    ready_mode = 0;
    model_clear();
    #3;
    check_reset_outputs("reset");
    check_eq("reset_state", dbg_state, IDLE);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // two pages of block 2, final block
    ready_mode = 1;
    send_block(6'd2, 64'h3, 1'b1);
    end_scan();

    // empty bitmap, then the highest page of the highest block
    send_block(6'd0, 64'h0, 1'b0);
    send_block(6'd63, 64'h8000_0000_0000_0000, 1'b1);
    end_scan();

    // ten matches, only the first eight kept
    send_block(6'd1, 64'h3FF, 1'b0);
    end_scan();

    // consumer blocked: FIFO fills, later match dropped
    ready_mode = 0;
    send_block(6'd3, 64'hFF, 1'b0);
    send_block(6'd4, 64'h20, 1'b1);
    @(negedge clk);
    check_eq("blk_out_valid", out_valid, 1);
    check_eq("blk_num_tpn", num_tpn, 8);
    check_eq("blk_overflow", overflow, 1);
    end_scan();

    // clear in the middle of a scan with three results queued
    ready_mode = 0;
    wait_in_ready();
    in_valid = 1'b1; in_bidx = 6'd5; in_eq = 64'h3F; in_last = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("mid_num_tpn", num_tpn, 3);
    check_eq("mid_state", dbg_state, SCAN);
    clear_scan();

    // asynchronous reset while DONE with results queued
    send_block(6'd7, 64'h5, 1'b1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_clear();
    @(negedge clk);
    rst = 1'b1;

    // randomized scans
    for (int s = 0; s < 10; s++) begin
      ready_mode = $urandom_range(0, 2);
      nblk = $urandom_range(1, 4);
      for (int b = 0; b < nblk; b++) begin
        case ($urandom_range(0, 3))
          0:       eq = 64'h0;
          1:       eq = 64'h1 << $urandom_range(0, 63);
          2:       eq = {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
          default: eq = {$urandom & $urandom, $urandom & $urandom};
        endcase
        send_block(6'($urandom_range(0, 63)), eq,
                   (b == nblk - 1) && ($urandom_range(0, 1) == 1));
      end
      end_scan();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
